// File: rtl/minbd_side_buffer_if.sv
// Flit bus between the router input latches and the side buffer.
// PORTS, FLIT_W and DEPTH must match the parameters of the attached buffer.
interface minbd_side_buffer_if #(
    parameter int FLIT_W = 11,
    parameter int PORTS  = 4,
    parameter int DEPTH  = 4
);
    logic [PORTS*FLIT_W-1:0]      in_flits;
    logic [PORTS*FLIT_W-1:0]      out_flits;
    logic [$clog2(DEPTH+1)-1:0]   count;
    logic                         empty;
    logic                         full;
    logic                         redirect;

    modport master (output in_flits, input out_flits, count, empty, full, redirect);
    modport slave  (input in_flits, output out_flits, count, empty, full, redirect);
endinterface

// File: rtl/minbd_side_buffer.sv
// MinBD side buffer: ejects one contending flit per cycle into a small FIFO,
// re-injects the head into a free slot, and swaps head/flit when starved.
module minbd_side_buffer #(
    parameter int FLIT_W       = 11,
    parameter int PORTS        = 4,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                clk,
    input  logic                rst,
    minbd_side_buffer_if.slave  bus
);
    localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [FLIT_W-1:0]              r_mem [DEPTH];
    logic [AW-1:0]                  r_rd, r_wr;
    logic [CW-1:0]                  r_count;
    logic [SW-1:0]                  r_starve;
    logic [PW-1:0]                  r_ptr;
    logic [PORTS-1:0][FLIT_W-1:0]   r_out;
    logic                           r_empty, r_full, r_redirect;

    logic [PORTS-1:0][FLIT_W-1:0]   w_in, w_out;
    logic [PORTS-1:0]               w_vld, w_cand;
    logic                           w_all_vld, w_found;
    logic [PW-1:0]                  w_sel, w_free;
    logic                           w_swap, w_eject, w_reinj, w_push, w_pop;
    logic [FLIT_W-1:0]              w_head;
    logic [CW-1:0]                  w_count_nxt;

    assign w_in   = bus.in_flits;
    assign w_head = r_mem[r_rd];

    always_comb begin
        for (int i = 0; i < PORTS; i++) begin
            w_vld[i]  = w_in[i][FLIT_W-1];
            w_cand[i] = w_in[i][FLIT_W-1] & ~w_in[i][FLIT_W-2];
        end
    end
    assign w_all_vld = &w_vld;

    // Round-robin scan from r_ptr; golden flits are never candidates.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int k = 0; k < PORTS; k++) begin
            if (!w_found && w_cand[(int'(r_ptr) + k) % PORTS]) begin
                w_found = 1'b1;
                w_sel   = PW'((int'(r_ptr) + k) % PORTS);
            end
        end
    end

    always_comb begin
        w_free = '0;
        for (int i = PORTS - 1; i >= 0; i--)
            if (!w_vld[i]) w_free = PW'(i);
    end

    assign w_swap  = (r_starve == SW'(STARVE_LIMIT)) && w_all_vld && w_found;
    assign w_eject = !w_swap && w_all_vld && !r_full && w_found;
    assign w_reinj = !r_empty && !w_all_vld;
    assign w_push  = w_swap | w_eject;
    assign w_pop   = w_swap | w_reinj;

    always_comb begin
        w_out = w_in;
        if (w_swap)       w_out[w_sel]  = w_head;
        else if (w_eject) w_out[w_sel]  = '0;
        else if (w_reinj) w_out[w_free] = w_head;
    end

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop)      w_count_nxt = r_count + 1'b1;
        else if (w_pop && !w_push) w_count_nxt = r_count - 1'b1;
    end

    // Swap on a full FIFO has r_wr==r_rd: the head is read before being overwritten.
    always_ff @(posedge clk) begin
        if (!rst && w_push) r_mem[r_wr] <= w_in[w_sel];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out      <= '0;
            r_count    <= '0;
            r_empty    <= 1'b1;
            r_full     <= 1'b0;
            r_redirect <= 1'b0;
            r_ptr      <= '0;
            r_starve   <= '0;
            r_rd       <= '0;
            r_wr       <= '0;
        end else begin
            r_out      <= w_out;
            r_count    <= w_count_nxt;
            r_empty    <= (w_count_nxt == '0);
            r_full     <= (w_count_nxt == CW'(DEPTH));
            r_redirect <= w_swap;
            if (w_push) begin
                r_wr  <= r_wr + 1'b1;
                r_ptr <= (w_sel == PW'(PORTS - 1)) ? '0 : w_sel + 1'b1;
            end
            if (w_pop) r_rd <= r_rd + 1'b1;
            if (w_pop || r_empty)
                r_starve <= '0;
            else if (r_starve != SW'(STARVE_LIMIT))
                r_starve <= r_starve + 1'b1;
        end
    end

    assign bus.out_flits = r_out;
    assign bus.count     = r_count;
    assign bus.empty     = r_empty;
    assign bus.full      = r_full;
    assign bus.redirect  = r_redirect;
endmodule

// File: tb/tb_minbd_side_buffer.sv
// Directed + random bench for minbd_side_buffer against a queue-based model.
module tb_minbd_side_buffer;
    localparam int FLIT_W = 11;
    localparam int PORTS  = 4;
    localparam int DEPTH  = 4;
    localparam int LIMIT  = 8;
    localparam int NW     = PORTS * FLIT_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    minbd_side_buffer_if #(.FLIT_W(FLIT_W), .PORTS(PORTS), .DEPTH(DEPTH)) bus ();

    minbd_side_buffer #(.FLIT_W(FLIT_W), .PORTS(PORTS), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [FLIT_W-1:0] q[$];
    int                m_ptr = 0;
    int                m_starve = 0;
    logic [NW-1:0]     e_out = '0;
    logic              e_red = 1'b0;
    int                n_red;

    task automatic chk(input string tag, input logic [NW-1:0] obs, input logic [NW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ptr = 0;
        m_starve = 0;
        e_out = '0;
        e_red = 1'b0;
    endtask

    task automatic model_step(input logic [NW-1:0] in);
        logic [FLIT_W-1:0] s [PORTS];
        logic [FLIT_W-1:0] head;
        int  sel, fr;
        bit  allv, was_empty, swap, ej, rj;
        was_empty = (q.size() == 0);
        allv = 1;
        sel = -1;
        fr = -1;
        for (int i = 0; i < PORTS; i++) begin
            s[i] = in[i*FLIT_W +: FLIT_W];
            if (!s[i][FLIT_W-1]) begin
                allv = 0;
                if (fr < 0) fr = i;
            end
        end
        for (int k = 0; k < PORTS; k++) begin
            int j;
            j = (m_ptr + k) % PORTS;
            if (sel < 0 && s[j][FLIT_W-1] && !s[j][FLIT_W-2]) sel = j;
        end
        swap = (m_starve == LIMIT) && allv && (sel >= 0);
        ej   = !swap && allv && (q.size() < DEPTH) && (sel >= 0);
        rj   = !was_empty && !allv;
        if (swap) begin
            head = q.pop_front();
            q.push_back(s[sel]);
            s[sel] = head;
            m_ptr = (sel + 1) % PORTS;
        end else if (ej) begin
            q.push_back(s[sel]);
            s[sel] = '0;
            m_ptr = (sel + 1) % PORTS;
        end else if (rj) begin
            s[fr] = q.pop_front();
        end
        if (swap || rj || was_empty) m_starve = 0;
        else if (m_starve < LIMIT) m_starve++;
        e_red = swap;
        for (int i = 0; i < PORTS; i++) e_out[i*FLIT_W +: FLIT_W] = s[i];
    endtask

    task automatic step(input logic r, input logic [NW-1:0] in);
        rst = r;
        bus.in_flits = in;
        @(posedge clk);
        if (r) model_reset();
        else model_step(in);
        #1;
        chk("out_flits", bus.out_flits, e_out);
        chk("count", NW'(bus.count), NW'(q.size()));
        chk("empty", NW'(bus.empty), NW'(q.size() == 0));
        chk("full", NW'(bus.full), NW'(q.size() == DEPTH));
        chk("redirect", NW'(bus.redirect), NW'(e_red));
        if (bus.redirect) n_red++;
    endtask

    function automatic logic [FLIT_W-1:0] rnd_flit();
        logic v, g;
        v = ($urandom_range(0, 99) < 85);
        g = ($urandom_range(0, 99) < 20);
        return {v, g, 9'($urandom)};
    endfunction

    logic [NW-1:0] all4, steady, rin;

    initial begin
        bus.in_flits = '0;
        all4   = {11'h404, 11'h403, 11'h402, 11'h401};
        steady = {11'h408, 11'h407, 11'h406, 11'h405};

        // reset with junk on the inputs
        step(1'b1, {$urandom, $urandom});
        step(1'b1, {$urandom, $urandom});
        chk("reset_out", bus.out_flits, '0);

        // round-robin eject
        step(1'b0, all4);
        chk("eject1_out", bus.out_flits, {11'h404, 11'h403, 11'h402, 11'h000});
        step(1'b0, all4);
        chk("eject2_out", bus.out_flits, {11'h404, 11'h403, 11'h000, 11'h401});
        chk("eject2_cnt", NW'(bus.count), NW'(2));

        // golden skip
        step(1'b1, '0);
        step(1'b0, {11'h404, 11'h403, 11'h402, 11'h601});
        chk("golden_skip", bus.out_flits, {11'h404, 11'h403, 11'h000, 11'h601});
        step(1'b0, {11'h604, 11'h603, 11'h602, 11'h601});
        chk("all_golden", bus.out_flits, {11'h604, 11'h603, 11'h602, 11'h601});
        chk("all_golden_cnt", NW'(bus.count), NW'(1));

        // re-inject head into the lowest free slot
        step(1'b1, '0);
        step(1'b0, all4);
        step(1'b0, all4);
        step(1'b0, {11'h404, 11'h000, 11'h403, 11'h000});
        chk("reinject", bus.out_flits, {11'h404, 11'h000, 11'h403, 11'h401});
        chk("reinject_cnt", NW'(bus.count), NW'(1));

        // fill, starve, then exactly one swap within the window
        n_red = 0;
        for (int c = 0; c < 14; c++) begin
            step(1'b0, steady);
            if (bus.redirect) chk("swap_cnt", NW'(bus.count), NW'(DEPTH));
        end
        chk("swap_once", NW'(n_red), NW'(1));

        // reset mid-operation drops buffered flits
        step(1'b1, '0);
        for (int c = 0; c < 3; c++) step(1'b0, all4);
        chk("pre_rst_cnt", NW'(bus.count), NW'(3));
        step(1'b1, all4);
        chk("mid_rst_cnt", NW'(bus.count), NW'(0));
        step(1'b0, {11'h000, 11'h000, 11'h000, 11'h403});
        chk("post_rst_pass", bus.out_flits, {11'h000, 11'h000, 11'h000, 11'h403});

        // random traffic
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < PORTS; i++) rin[i*FLIT_W +: FLIT_W] = rnd_flit();
            step(($urandom_range(0, 99) == 0), rin);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
